// File: rtl/cnu_serial_minfind_if.sv
// Handshake bundle for the serial check-node min-finder: message input and
// compressed check-node result output.
interface cnu_serial_minfind_if #(
    parameter int unsigned data_w = 9,
    parameter int unsigned DEG    = 6
);
    localparam int unsigned idx_w = $clog2(DEG);

    logic                in_valid;
    logic                in_ready;
    logic [data_w-1:0]   in_msg;
    logic                out_valid;
    logic                out_ready;
    logic [data_w-2:0]   out_min1;
    logic [data_w-2:0]   out_min2;
    logic [idx_w-1:0]    out_idx;
    logic                out_sign;
    logic [DEG-1:0]      out_signs;

    modport slave (
        input  in_valid, in_msg, out_ready,
        output in_ready, out_valid, out_min1, out_min2, out_idx, out_sign, out_signs
    );

    modport master (
        output in_valid, in_msg, out_ready,
        input  in_ready, out_valid, out_min1, out_min2, out_idx, out_sign, out_signs
    );
endinterface

// File: rtl/cnu_serial_minfind.sv
// Serial check-node processor: accumulates min1/min2/index/sign parity over
// DEG sign-magnitude messages and emits one compressed result per frame.
module cnu_serial_minfind #(
    parameter int unsigned data_w = 9,
    parameter int unsigned DEG    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    cnu_serial_minfind_if.slave cnu
);
    localparam int unsigned mag_w = data_w - 1;
    localparam int unsigned idx_w = $clog2(DEG);

    typedef enum logic {ACCUM, OUT} state_e;

    state_e              state_q;
    logic [idx_w-1:0]    k_q;
    logic [mag_w-1:0]    min1_q, min1_d;
    logic [mag_w-1:0]    min2_q, min2_d;
    logic [idx_w-1:0]    idx_q, idx_d;
    logic                sign_q, sign_d;
    logic [DEG-1:0]      signs_q, signs_d;

    logic [mag_w-1:0]    out_min1_q, out_min2_q;
    logic [idx_w-1:0]    out_idx_q;
    logic                out_sign_q;
    logic [DEG-1:0]      out_signs_q;

    logic [mag_w-1:0]    m;
    logic                s;
    logic                xfer;
    logic                last;

    assign m    = cnu.in_msg[mag_w-1:0];
    assign s    = cnu.in_msg[data_w-1];
    assign xfer = cnu.in_valid && (state_q == ACCUM);
    assign last = (k_q == idx_w'(DEG - 1));

    // Running min1/min2/index/sign update for the message on the bus
    always_comb begin
        min1_d  = min1_q;
        min2_d  = min2_q;
        idx_d   = idx_q;
        sign_d  = sign_q ^ s;
        signs_d = signs_q;
        if (k_q == '0) begin
            min1_d     = m;
            min2_d     = '1;
            idx_d      = '0;
            sign_d     = s;
            signs_d    = '0;
            signs_d[0] = s;
        end else begin
            // Strict compares: an equal magnitude never displaces the earlier edge
            if (m < min1_q) begin
                min2_d = min1_q;
                min1_d = m;
                idx_d  = k_q;
            end else if (m < min2_q) begin
                min2_d = m;
            end
            signs_d[k_q] = s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            k_q         <= '0;
            min1_q      <= '1;
            min2_q      <= '1;
            idx_q       <= '0;
            sign_q      <= 1'b0;
            signs_q     <= '0;
            out_min1_q  <= '0;
            out_min2_q  <= '0;
            out_idx_q   <= '0;
            out_sign_q  <= 1'b0;
            out_signs_q <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (xfer) begin
                        min1_q  <= min1_d;
                        min2_q  <= min2_d;
                        idx_q   <= idx_d;
                        sign_q  <= sign_d;
                        signs_q <= signs_d;
                        if (last) begin
                            k_q         <= '0;
                            out_min1_q  <= min1_d;
                            out_min2_q  <= min2_d;
                            out_idx_q   <= idx_d;
                            out_sign_q  <= sign_d;
                            out_signs_q <= signs_d;
                            state_q     <= OUT;
                        end else begin
                            k_q <= k_q + idx_w'(1);
                        end
                    end
                end
                OUT: begin
                    if (cnu.out_ready) begin
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign cnu.in_ready  = (state_q == ACCUM);
    assign cnu.out_valid = (state_q == OUT);
    assign cnu.out_min1  = out_min1_q;
    assign cnu.out_min2  = out_min2_q;
    assign cnu.out_idx   = out_idx_q;
    assign cnu.out_sign  = out_sign_q;
    assign cnu.out_signs = out_signs_q;
endmodule

// File: tb/tb_cnu_serial_minfind.sv
// Scoreboard bench for cnu_serial_minfind: directed frames push expected
// results; a monitor pops and compares on each accepted output.
module tb_cnu_serial_minfind;
    localparam int unsigned DATA_W = 9;
    localparam int unsigned DEG    = 6;

    typedef struct {
        int min1;
        int min2;
        int idx;
        int sign;
        int signs;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    exp_t exp_q[$];
    int   out_cyc[$];

    cnu_serial_minfind_if #(.data_w(DATA_W), .DEG(DEG)) ifc ();

    cnu_serial_minfind #(.data_w(DATA_W), .DEG(DEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cnu   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic void push_exp(int a, int b, int c, int d, int e);
        exp_t x;
        x.min1 = a; x.min2 = b; x.idx = c; x.sign = d; x.signs = e;
        exp_q.push_back(x);
    endfunction

    // Monitor: compare every accepted result against the scoreboard head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(ifc.out_valid), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("min1",  64'(ifc.out_min1),  64'(e.min1));
                chk("min2",  64'(ifc.out_min2),  64'(e.min2));
                chk("idx",   64'(ifc.out_idx),   64'(e.idx));
                chk("sign",  64'(ifc.out_sign),  64'(e.sign));
                chk("signs", 64'(ifc.out_signs), 64'(e.signs));
                out_cyc.push_back(cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ifc.in_valid = 1'b0;
        end
    endtask

    task automatic send(input int mag, input int sg);
        int n;
        n = 0;
        @(negedge clk);
        while (ifc.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (ifc.in_ready !== 1'b1) chk("in_ready_timeout", 64'(ifc.in_ready), 64'(1));
        ifc.in_valid = 1'b1;
        ifc.in_msg   = {sg[0], mag[7:0]};
        @(posedge clk);
    endtask

    task automatic run_frame(input int m[6], input int s[6], input int gaps);
        for (int i = 0; i < 6; i++) begin
            if (gaps != 0) idle(int'($urandom_range(0, 2)));
            send(m[i], s[i]);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},  64'(ifc.in_ready),  64'(1));
        chk({tag, "_out_valid"}, 64'(ifc.out_valid), 64'(0));
        chk({tag, "_min1"},      64'(ifc.out_min1),  64'(0));
        chk({tag, "_min2"},      64'(ifc.out_min2),  64'(0));
        chk({tag, "_idx"},       64'(ifc.out_idx),   64'(0));
        chk({tag, "_signs"},     64'({ifc.out_sign, ifc.out_signs}), 64'(0));
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("scoreboard_drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int base;
        checks       = 0;
        failures     = 0;
        ifc.in_valid = 1'b0;
        ifc.in_msg   = '0;
        ifc.out_ready = 1'b1;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst0");
        rst_n = 1'b1;

        // Basic frame with 5 cycles of backpressure
        ifc.out_ready = 1'b0;
        push_exp(7, 12, 3, 0, 0);
        run_frame('{40, 12, 33, 7, 90, 15}, '{0, 0, 0, 0, 0, 0}, 0);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        chk("latency_out_valid", 64'(ifc.out_valid), 64'(1));
        repeat (5) begin
            chk("bp_out_valid", 64'(ifc.out_valid), 64'(1));
            chk("bp_in_ready",  64'(ifc.in_ready),  64'(0));
            chk("bp_min1",      64'(ifc.out_min1),  64'(7));
            chk("bp_min2",      64'(ifc.out_min2),  64'(12));
            chk("bp_idx",       64'(ifc.out_idx),   64'(3));
            @(negedge clk);
        end
        @(posedge clk);
        #1 ifc.out_ready = 1'b1;
        wait_empty(20);

        // Ties, back to back
        push_exp(5, 5, 0, 0, 0);
        push_exp(8, 8, 0, 0, 0);
        run_frame('{5, 5, 9, 5, 20, 30}, '{0, 0, 0, 0, 0, 0}, 0);
        run_frame('{8, 8, 8, 8, 8, 8}, '{0, 0, 0, 0, 0, 0}, 0);
        idle(1);
        wait_empty(20);

        // Sign parity and per-edge sign vector
        push_exp(10, 11, 0, 1, 6'b001101);
        run_frame('{10, 11, 12, 13, 14, 15}, '{1, 0, 1, 1, 0, 0}, 0);
        idle(1);
        wait_empty(20);

        // Descending with gaps, then continuous frame for throughput
        base = out_cyc.size();
        push_exp(10, 20, 5, 0, 0);
        push_exp(1, 2, 2, 0, 0);
        run_frame('{60, 50, 40, 30, 20, 10}, '{0, 0, 0, 0, 0, 0}, 1);
        run_frame('{3, 9, 1, 7, 2, 8}, '{0, 0, 0, 0, 0, 0}, 0);
        idle(1);
        wait_empty(20);
        if (out_cyc.size() >= base + 2)
            chk("throughput_gap", 64'(out_cyc[base + 1] - out_cyc[base]), 64'(DEG + 1));
        else
            chk("throughput_count", 64'(out_cyc.size() - base), 64'(2));

        // All-ones magnitudes
        push_exp(255, 255, 0, 0, 0);
        run_frame('{255, 255, 255, 255, 255, 255}, '{0, 0, 0, 0, 0, 0}, 0);
        idle(1);
        wait_empty(20);

        // Reset mid-frame after 3 transfers
        send(0, 1);
        send(0, 1);
        send(0, 1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("rst_mid");
        rst_n = 1'b1;

        // Fresh frame, with in_valid pulses during OUT that must be ignored
        ifc.out_ready = 1'b0;
        push_exp(1, 2, 3, 0, 0);
        run_frame('{4, 3, 2, 1, 6, 5}, '{0, 0, 0, 0, 0, 0}, 0);
        repeat (3) begin
            @(negedge clk);
            ifc.in_valid = 1'b1;
            ifc.in_msg   = '0;
            chk("out_in_ready", 64'(ifc.in_ready),  64'(0));
            chk("out_min1_hold", 64'(ifc.out_min1), 64'(1));
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1 ifc.out_ready = 1'b1;
        wait_empty(20);

        push_exp(7, 12, 3, 1, 6'b100000);
        run_frame('{40, 12, 33, 7, 90, 15}, '{0, 0, 0, 0, 0, 1}, 0);
        idle(1);
        wait_empty(20);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cnu_serial_minfind.md
Name: cnu_serial_minfind

Overview:
- Serial check-node magnitude processor for the LDPC decoder CNU.
- Accepts DEG sign-magnitude variable-to-check messages, one per handshake. Tracks min1, min2, the index of min1, the total sign parity and the per-edge sign vector.
- After DEG accepted messages, presents one compressed check-node result on a ready/valid output, for use by the check-to-variable message generator.
- Used where the combinational 3-input min stage is too wide for a high-degree node.

Parameters:
- data_w, 9, message width; bit data_w-1 is the sign, bits data_w-2:0 are the unsigned magnitude.
- DEG, 6, check-node degree (messages per frame); legal range 2..64.
- idx_w, $clog2(DEG), localparam, width of the edge index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input message valid.
- in_ready  out  1  block can accept a message this cycle.
- in_msg  in  data_w  sign-magnitude message for the current edge.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_min1  out  data_w-1  smallest magnitude in the frame.
- out_min2  out  data_w-1  second smallest magnitude in the frame.
- out_idx  out  idx_w  edge index (0..DEG-1) of min1.
- out_sign  out  1  XOR of all DEG sign bits.
- out_signs  out  DEG  per-edge sign bits; bit k is the sign of edge k.

Behaviour:
- One clock, one reset. Reset is synchronous, active-low, and sampled on the clk rising edge.
- Reset values: state=ACCUM, edge counter=0, in_ready=1, out_valid=0. out_min1, out_min2, out_idx, out_sign and out_signs are 0. Internal min1 and min2 are all ones.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - OUT: in_ready=0, out_valid=1.
- Input transfer occurs when in_valid && in_ready. Let m = in_msg magnitude, s = in_msg sign, k = edge counter.
- Update on each transfer:
  - If k==0: min1<=m, min2<=all ones, idx<=0, sign_acc<=s, signs<={0..,s}.
  - Else if m < min1 (strict): min2<=min1, min1<=m, idx<=k.
  - Else if m < min2 (strict): min2<=m.
  - sign_acc ^= s; signs[k]<=s.
- Ties: an equal magnitude never displaces min1, so the earliest edge wins. An equal magnitude displaces min2 only if it is strictly smaller than min2; with min1==min2 this leaves min2 unchanged.
- Counter: k increments on each transfer. On the transfer with k==DEG-1:
  - k wraps to 0.
  - Final values are registered to the out_* ports, including the update from this last message.
  - State goes to OUT.
- Latency: out_valid rises in the cycle after the last input transfer.
- OUT state:
  - Outputs are held stable while out_valid && !out_ready.
  - When out_valid && out_ready, return to ACCUM; in_ready is 1 on the next cycle.
  - Sustained throughput is DEG+1 cycles per frame with no bubble beyond the single output cycle.
- in_valid during OUT is ignored (in_ready=0), and no state changes.
- in_valid gaps within a frame do not affect results; the counter advances only on transfers.
- All-ones magnitude input: handled normally. If every magnitude is all ones, min2 = all ones and idx = 0.
- Reset mid-frame or during OUT: partial frame is discarded, all registers return to reset values, and the next transfer is edge 0.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid are decoded from registered state only.

Test Plan (data_w=9, DEG=6):
- Reset then frame of magnitudes 40,12,33,7,90,15, all signs 0, in_valid held high -> out_valid on the cycle after the 6th transfer. Expected min1=7, min2=12, idx=3, out_sign=0, out_signs=6'b000000. Backpressure out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
- Ties: magnitudes 5,5,9,5,20,30 -> min1=5, min2=5, idx=0. Then frame 8,8,8,8,8,8 -> min1=8, min2=8, idx=0.
- Signs: frame with signs 1,0,1,1,0,0 and magnitudes 10..15 ascending -> out_sign=1, out_signs=6'b001101, min1=10, min2=11, idx=0.
- Descending magnitudes 60,50,40,30,20,10 with random in_valid gaps -> min1=10, min2=20, idx=5. Then a back-to-back second frame with out_ready=1 -> second out_valid exactly DEG+1 cycles after the first when in_valid is continuous.
- All magnitudes 255 -> min1=255, min2=255, idx=0.
- Reset mid-frame after 3 transfers, then a full frame of 4,3,2,1,6,5 -> min1=1, min2=2, idx=3, with no contamination from the discarded partial frame. in_valid pulses during OUT are not consumed.
